// File: rtl/cam_pkg.sv
// cam_pkg: shared CAM geometry, opcode encoding and request/response records.
package cam_pkg;

    localparam int CAM_ENTRIES = 32;
    localparam int IDX_W       = 5;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        READ   = 2'b00,
        WRITE  = 2'b01,
        SEARCH = 2'b10,
        RSVD   = 2'b11
    } cam_op_e;

    typedef struct packed {
        cam_op_e           op;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } cam_req_t;

    typedef struct packed {
        cam_op_e           op;
        logic              hit;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } cam_resp_t;

endpackage

// File: rtl/cam_req_fifo.sv
// cam_req_fifo: DEPTH-entry request FIFO; pointers carry an extra wrap bit to tell full from empty.
module cam_req_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  cam_req_t               push_data,
    output cam_req_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    cam_req_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign empty    = wr_ptr == rd_ptr;
    assign full     = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cam_cmd_sequencer.sv
// cam_cmd_sequencer: queues CAM requests, issues one CAM operation at a time
// and returns one in-order response per request.
module cam_cmd_sequencer
    import cam_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CAM_LAT = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [IDX_W-1:0]       req_index_i,
    input  logic [DATA_W-1:0]      req_data_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [1:0]             resp_op_o,
    output logic                   resp_hit_o,
    output logic [IDX_W-1:0]       resp_index_o,
    output logic [DATA_W-1:0]      resp_data_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   read_enable_o,
    output logic [IDX_W-1:0]       read_index_o,
    output logic                   write_enable_o,
    output logic [IDX_W-1:0]       write_index_o,
    output logic [DATA_W-1:0]      write_data_o,
    output logic                   search_enable_o,
    output logic [DATA_W-1:0]      search_data_o,
    input  logic                   read_valid_i,
    input  logic [DATA_W-1:0]      read_value_i,
    input  logic                   search_valid_i,
    input  logic [IDX_W-1:0]       search_index_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                 state;
    cam_req_t               req;
    cam_req_t               head;
    cam_req_t               cur;
    cam_resp_t              resp;
    logic [1:0]             cnt;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   issue;
    logic                   rsp;
    logic [$clog2(DEPTH):0] count;

    assign req  = '{op: cam_op_e'(req_op_i), index: req_index_i, data: req_data_i};
    assign push = req_valid_i && req_ready_o;
    assign pop  = state == IDLE && !empty;

    cam_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .push_data (req),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cur   <= '0;
            resp  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    cur   <= head;
                    state <= ISSUE;
                end
                ISSUE: if (cur.op == READ || cur.op == SEARCH) begin
                    cnt   <= 2'(CAM_LAT - 1);
                    state <= WAIT;
                end else begin
                    resp  <= {cur.op, cur.op == WRITE, cur.op == WRITE ? cur.index : 5'd0,
                              cur.op == WRITE ? cur.data : 32'd0};
                    state <= RESP;
                end
                // The CAM result is valid exactly CAM_LAT cycles after the enable.
                WAIT: if (cnt == 2'd0) begin
                    resp  <= cur.op == READ ? {cur.op, read_valid_i, cur.index, read_value_i}
                           : {cur.op, search_valid_i, search_valid_i ? search_index_i : 5'd0, 32'd0};
                    state <= RESP;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                RESP: if (resp_ready_i) state <= IDLE;
            endcase
        end
    end

    // Every output is held at zero while reset is asserted.
    assign issue           = state == ISSUE && !rst_i;
    assign rsp             = state == RESP && !rst_i;
    assign req_ready_o     = !full && !rst_i;
    assign busy_o          = state != IDLE && !rst_i;
    assign fifo_count_o    = rst_i ? '0 : count;
    assign read_enable_o   = issue && cur.op == READ;
    assign write_enable_o  = issue && cur.op == WRITE;
    assign search_enable_o = issue && cur.op == SEARCH;
    assign read_index_o    = read_enable_o ? cur.index : '0;
    assign write_index_o   = write_enable_o ? cur.index : '0;
    assign write_data_o    = write_enable_o ? cur.data : '0;
    assign search_data_o   = search_enable_o ? cur.data : '0;
    assign resp_valid_o    = rsp;
    assign resp_op_o       = rsp ? resp.op : 2'b00;
    assign resp_hit_o      = rsp && resp.hit;
    assign resp_index_o    = rsp ? resp.index : '0;
    assign resp_data_o     = rsp ? resp.data : '0;

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// tb_cam_cmd_sequencer: two sequencers (CAM_LAT 1 and 3) each driving a behavioural CAM,
// checked by a per-instance scoreboard fed from a request-level reference model.
module tb_cam_cmd_sequencer;
    import cam_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]       req_valid, req_ready, resp_valid, resp_ready, resp_hit, busy, rd_en, wr_en, se_en;
    logic [1:0][1:0]  req_op, resp_op;
    logic [1:0][4:0]  req_index, resp_index, rd_idx, wr_idx;
    logic [1:0][31:0] req_data, resp_data, wr_data, se_data;
    logic [1:0][2:0]  fifo_count;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = g == 0 ? 1 : 3;
        logic        rv, sv;
        logic [31:0] rval;
        logic [4:0]  sidx;
        logic [31:0] mem [32];
        logic        vld [32];
        logic [38:0] look;
        logic [38:0] pipe [LAT];
        cam_resp_t   q [$];
        logic [31:0] sh_mem [32];
        logic        sh_vld [32];

        cam_cmd_sequencer #(.DEPTH(4), .CAM_LAT(LAT)) dut (
            .clk_i(clk), .rst_i(rst),
            .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]), .req_op_i(req_op[g]),
            .req_index_i(req_index[g]), .req_data_i(req_data[g]),
            .resp_valid_o(resp_valid[g]), .resp_ready_i(resp_ready[g]), .resp_op_o(resp_op[g]),
            .resp_hit_o(resp_hit[g]), .resp_index_o(resp_index[g]), .resp_data_o(resp_data[g]),
            .busy_o(busy[g]), .fifo_count_o(fifo_count[g]),
            .read_enable_o(rd_en[g]), .read_index_o(rd_idx[g]),
            .write_enable_o(wr_en[g]), .write_index_o(wr_idx[g]), .write_data_o(wr_data[g]),
            .search_enable_o(se_en[g]), .search_data_o(se_data[g]),
            .read_valid_i(rv), .read_value_i(rval), .search_valid_i(sv), .search_index_i(sidx)
        );

        // Behavioural CAM: results appear LAT cycles after the enable cycle.
        always_comb begin
            look = '0;
            if (rd_en[g]) look[38:6] = {vld[rd_idx[g]], mem[rd_idx[g]]};
            if (se_en[g])
                for (int i = 31; i >= 0; i--)
                    if (vld[i] && mem[i] == se_data[g]) look[5:0] = {1'b1, 5'(i)};
        end

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    mem[i] <= '0;
                    vld[i] <= 1'b0;
                end
            end else if (wr_en[g]) begin
                mem[wr_idx[g]] <= wr_data[g];
                vld[wr_idx[g]] <= 1'b1;
            end
            pipe[0] <= rst ? '0 : look;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign {rv, rval, sv, sidx} = pipe[LAT-1];

        // Reference model: requests execute in push order, so a shadow of CAM contents
        // updated at push time gives each request's expected response.
        function automatic cam_resp_t model(input logic [1:0] op, input logic [4:0] ix, input logic [31:0] d);
            cam_resp_t e;
            e    = '0;
            e.op = cam_op_e'(op);
            if (op == 2'd0) begin
                e.hit   = sh_vld[ix];
                e.index = ix;
                e.data  = sh_mem[ix];
            end else if (op == 2'd1) begin
                e.hit   = 1'b1;
                e.index = ix;
                e.data  = d;
            end else if (op == 2'd2) begin
                for (int i = 31; i >= 0; i--)
                    if (sh_vld[i] && sh_mem[i] == d) begin
                        e.hit   = 1'b1;
                        e.index = 5'(i);
                    end
            end
            return e;
        endfunction

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                for (int i = 0; i < 32; i++) begin
                    sh_mem[i] <= '0;
                    sh_vld[i] <= 1'b0;
                end
                chk("reset_outputs", 64'({req_ready[g], resp_valid[g], busy[g], fifo_count[g], rd_en[g], wr_en[g],
                    se_en[g], rd_idx[g], wr_idx[g], wr_data[g]}), 64'd0);
                chk("reset_resp", 64'({resp_op[g], resp_hit[g], resp_index[g], resp_data[g], se_data[g][15:0]}), 64'd0);
            end else begin
                if (resp_valid[g]) begin
                    if (q.size() == 0) chk("unexpected_response", 64'(resp_valid[g]), 64'd0);
                    else begin
                        chk("response", 64'({resp_op[g], resp_hit[g], resp_index[g], resp_data[g]}), 64'(q[0]));
                        if (resp_ready[g]) void'(q.pop_front());
                    end
                end
                if (req_valid[g] && req_ready[g]) begin
                    q.push_back(model(req_op[g], req_index[g], req_data[g]));
                    if (req_op[g] == 2'd1) begin
                        sh_mem[req_index[g]] <= req_data[g];
                        sh_vld[req_index[g]] <= 1'b1;
                    end
                end
            end
        end
    end

    // Single request into an idle instance; checks the ISSUE-cycle enable and response latency.
    task automatic one(input int g, input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d, input int lat);
        int n;
        logic [2:0] exp_en;
        exp_en        = op == 2'd3 ? 3'b000 : 3'b100 >> op;
        req_valid[g]  = 1'b1;
        req_op[g]     = op;
        req_index[g]  = idx;
        req_data[g]   = d;
        resp_ready[g] = 1'b1;
        @(posedge clk);
        #1 req_valid[g] = 1'b0;
        for (n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 2) chk("issue_enables", 64'({rd_en[g], wr_en[g], se_en[g]}), 64'(exp_en));
            if (resp_valid[g]) break;
            @(posedge clk);
            #1;
        end
        chk("latency", 64'(n), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d);
        int t;
        req_valid[g] = 1'b1;
        req_op[g]    = op;
        req_index[g] = idx;
        req_data[g]  = d;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[g]) break;
            @(posedge clk);
            #1;
        end
        if (t == 20) chk("push_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1 req_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy[g] && fifo_count[g] == 3'd0) break;
            @(posedge clk);
            #1;
        end
        chk("idle", 64'({busy[g], fifo_count[g]}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid  = '0;
        req_op     = '0;
        req_index  = '0;
        req_data   = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        one(0, 2'd1, 5'd3, 32'hDEADBEEF, 3);
        one(0, 2'd0, 5'd3, 32'd0, 4);
        one(0, 2'd0, 5'd7, 32'd0, 4);
        one(0, 2'd2, 5'd0, 32'hDEADBEEF, 4);
        one(0, 2'd2, 5'd0, 32'h12345678, 4);
        one(1, 2'd1, 5'd3, 32'hDEADBEEF, 3);
        one(1, 2'd2, 5'd0, 32'hDEADBEEF, 6);
        one(1, 2'd2, 5'd0, 32'h12345678, 6);
        one(1, 2'd0, 5'd3, 32'd0, 6);
        one(0, 2'd3, 5'd5, 32'hFFFFFFFF, 3);

        // Backpressure: the first response is held while four more requests fill the FIFO.
        resp_ready[0] = 1'b0;
        for (int k = 0; k < 5; k++) push(0, 2'd1, 5'(k + 8), 32'hC0DE0000 + k);
        @(negedge clk);
        chk("bp_count", 64'(fifo_count[0]), 64'd4);
        chk("bp_ready", 64'(req_ready[0]), 64'd0);
        @(posedge clk);
        #1 resp_ready[0] = 1'b1;
        wait_idle(0);
        chk("bp_drained", 64'(u[0].q.size()), 64'd0);

        // Reset while instance 1 waits on a READ with two more queued.
        resp_ready[1] = 1'b1;
        push(1, 2'd0, 5'd3, 32'd0);
        push(1, 2'd1, 5'd9, 32'h00000001);
        push(1, 2'd2, 5'd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("pre_reset_count", 64'({busy[1], fifo_count[1]}), 64'({1'b1, 3'd2}));
        @(posedge clk);
        #1;
        rst          = 1'b1;
        req_valid[0] = 1'b1;
        req_op[0]    = 2'd1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("post_reset_1", 64'({busy[1], fifo_count[1], resp_valid[1]}), 64'd0);
        chk("post_reset_0", 64'({busy[0], fifo_count[0]}), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        one(0, 2'd0, 5'd3, 32'd0, 4);
        one(1, 2'd0, 5'd3, 32'd0, 6);

        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < 2; g++) begin
                req_valid[g]  = 1'($urandom_range(0, 1));
                req_op[g]     = 2'($urandom_range(0, 3));
                req_index[g]  = 5'($urandom_range(0, 7));
                req_data[g]   = $urandom_range(0, 1) == 1 ? 32'($urandom_range(0, 3)) : $urandom;
                resp_ready[g] = $urandom_range(0, 3) != 0;
            end
            @(posedge clk);
            #1;
        end
        req_valid  = '0;
        resp_ready = 2'b11;
        wait_idle(0);
        wait_idle(1);
        chk("final_queue_0", 64'(u[0].q.size()), 64'd0);
        chk("final_queue_1", 64'(u[1].q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
